// File: rtl/gpio_debounce.sv
// gpio_debounce: input conditioning for up to WIDTH raw GPIO pads.
// Each pin goes through a two-flop synchronizer and a per-pin debounce
// counter. The qualified level appears on stable_o, which feeds the GPIO
// block's input_i.
// Optional feature macro GPIO_DEBOUNCE_IRQ_EN:
//   - When defined, sticky rise/fall edge flags and a maskable level
//     interrupt are built.
//   - When undefined, rise_o, fall_o and irq_o are tied low, and clr_i and
//     irq_en_i are ignored.
module gpio_debounce #(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] pins_i,
  output logic [WIDTH-1:0] stable_o,
  input  logic [WIDTH-1:0] clr_i,
  input  logic [WIDTH-1:0] irq_en_i,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic             irq_o
);

  // Terminal count: the sample that completes qualification.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Two-flop synchronizer; only s2_q is consumed downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pins_i;
      s2_q <= s1_q;
    end
  end

  // Per-pin qualification.
  // - Agreement with the stable level clears the count, so a short glitch
  //   leaves no residue.
  // - The count stops at CNT_MAX, where the new level is accepted, so it
  //   never wraps.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Debounce state registers; reset drops any in-progress count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign stable_o = stable_q;

`ifdef GPIO_DEBOUNCE_IRQ_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;

  // Sticky edge flags.
  // - A new edge on stable_o wins over a same-cycle clear.
  // - Clearing a pin that has no flag set is harmless.
  always_comb begin
    rise_d = (rise_q & ~clr_i) | (stable_d & ~stable_q);
    fall_d = (fall_q & ~clr_i) | (~stable_d & stable_q);
  end

  // Edge flag registers, updated on the same edge as stable_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
  // Combinational from the flag flops, so masking takes effect immediately.
  assign irq_o  = |((rise_q | fall_q) & irq_en_i);
`else
  // Flag and interrupt logic is not built; its control inputs are unused.
  logic unused_irq_ctrl;
  assign unused_irq_ctrl = ^{clr_i, irq_en_i};

  assign rise_o = '0;
  assign fall_o = '0;
  assign irq_o  = 1'b0;
`endif

endmodule
